// File: rtl/seg_source_mux_if.sv
// Bus between the display-source logic and the seven-segment source mux.
// The master side drives the button, mode, force and pattern inputs; the
// slave side (the mux) returns the registered segment, anode and select pins.
interface seg_source_mux_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                      btn_next;
  logic                      mode;
  logic [NCH-1:0]            force_en;
  logic [NCH*DIGITS*7-1:0]   src_seg;
  logic [6:0]                seg;
  logic [DIGITS-1:0]         an;
  logic [SELW-1:0]           sel;

  modport master (
    output btn_next, mode, force_en, src_seg,
    input  seg, an, sel
  );

  modport slave (
    input  btn_next, mode, force_en, src_seg,
    output seg, an, sel
  );
endinterface

// File: rtl/seg_source_mux.sv
// N-channel source arbiter and scan driver for a multiplexed 7-segment display.
// Channel choice: lowest forced channel, else a step register advanced by a
// debounced button (manual) or a periodic timer (auto). The chosen channel is
// scanned digit by digit; a channel change costs one blank slot so the old
// pattern never ghosts onto the new channel's digits.
module seg_source_mux #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned AUTO_PERIOD = 100000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seg_source_mux_if.slave  bus
);

  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DIGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned REFW = $clog2(REFRESH_DIV);
  localparam int unsigned DEBW = $clog2(DEB_CYCLES);
  localparam int unsigned AUTW = $clog2(AUTO_PERIOD);

  // Button path
  logic [1:0]      r_sync;
  logic            w_btn_s;
  logic [DEBW-1:0] r_deb_cnt;
  logic            r_btn_acc;
  logic            r_next_pulse;

  // Channel stepping
  logic [AUTW-1:0] r_auto_cnt;
  logic            w_auto_tick;
  logic [SELW-1:0] r_step;
  logic [SELW-1:0] w_active;

  // Scanner
  logic [REFW-1:0] r_ref_cnt;
  logic            w_slot_end;
  logic [DIGW-1:0] r_digit;
  logic [6:0]      w_pat;
  logic [6:0]      r_seg;
  logic [DIGITS-1:0] r_an;
  logic [SELW-1:0] r_sel;

  assign w_btn_s     = r_sync[1];
  assign w_auto_tick = bus.mode && (r_auto_cnt == AUTW'(AUTO_PERIOD - 1));
  assign w_slot_end  = (r_ref_cnt == REFW'(REFRESH_DIV - 1));

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.sel = r_sel;

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.btn_next};
    end
  end

  // Debouncer: accept a new level only after it has held for DEB_CYCLES clocks;
  // a rising accepted level yields a one-cycle advance pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deb_cnt    <= '0;
      r_btn_acc    <= 1'b0;
      r_next_pulse <= 1'b0;
    end else begin
      r_next_pulse <= 1'b0;
      if (w_btn_s != r_btn_acc) begin
        if (r_deb_cnt == DEBW'(DEB_CYCLES - 1)) begin
          r_btn_acc    <= w_btn_s;
          r_deb_cnt    <= '0;
          r_next_pulse <= w_btn_s;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEBW'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Auto-rotate timer: held at zero in manual mode, restarted by a button advance
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_auto_cnt <= '0;
    end else if (!bus.mode || r_next_pulse || w_auto_tick) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTW'(1);
    end
  end

  // Step register: one advance per cycle whether from button, tick, or both
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step <= '0;
    end else if (r_next_pulse || w_auto_tick) begin
      if (r_step == SELW'(NCH - 1)) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + SELW'(1);
      end
    end
  end

  // Active channel: lowest forced index wins, otherwise the step register
  always_comb begin
    w_active = r_step;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (bus.force_en[i]) begin
        w_active = SELW'(i);
      end
    end
  end

  // Pattern of the currently displayed channel at the current digit
  always_comb begin
    w_pat = 7'h7F;
    for (int c = 0; c < int'(NCH); c++) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        if ((r_sel == SELW'(c)) && (r_digit == DIGW'(d))) begin
          w_pat = bus.src_seg[(c * int'(DIGITS) + d) * 7 +: 7];
        end
      end
    end
  end

  // Slot timer for the digit scan
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_cnt <= '0;
    end else if (w_slot_end) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + REFW'(1);
    end
  end

  // Slot boundary: advance the digit and either blank (channel switch) or drive it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= '0;
      r_seg   <= 7'h7F;
      r_an    <= '1;
      r_sel   <= '0;
    end else if (w_slot_end) begin
      if (r_digit == DIGW'(DIGITS - 1)) begin
        r_digit <= '0;
      end else begin
        r_digit <= r_digit + DIGW'(1);
      end
      if (w_active != r_sel) begin
        r_sel <= w_active;
        r_an  <= '1;
        r_seg <= 7'h7F;
      end else begin
        r_an  <= ~(DIGITS'(1) << r_digit);
        r_seg <= w_pat;
      end
    end
  end

endmodule

// File: tb/tb_seg_source_mux.sv
// Self-checking bench for seg_source_mux: a cycle-level behavioural model
// (counts of cycles, slot arithmetic, modulo stepping) is compared against the
// DUT every cycle, with literal expectations at the directed checkpoints.
module tb_seg_source_mux;

  localparam int unsigned NCH         = 4;
  localparam int unsigned DIGITS      = 4;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned DEB_CYCLES  = 8;
  localparam int unsigned AUTO_PERIOD = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_source_mux_if #(.NCH(NCH), .DIGITS(DIGITS)) bus ();

  seg_source_mux #(
    .NCH(NCH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV),
    .DEB_CYCLES(DEB_CYCLES), .AUTO_PERIOD(AUTO_PERIOD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  int         m_cyc, m_s1, m_s2, m_acc, m_run, m_pulse, m_step, m_age, m_sel;
  logic [6:0] m_seg;
  logic [3:0] m_an;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_force(input logic [NCH-1:0] f);
    for (int i = 0; i < int'(NCH); i++) if (f[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_cyc = 0; m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_pulse = 0;
    m_step = 0; m_age = 0; m_sel = 0;
    m_seg = 7'h7F; m_an = 4'hF;
  endtask

  // One clock of the model, using the inputs as they stood before the edge
  task automatic m_clock();
    int sync, act, adv, pulse_now, d;
    sync = m_s2;
    m_cyc++;
    act = lowest_force(bus.force_en);
    if (act < 0) act = m_step;
    if (m_cyc % REFRESH_DIV == 0) begin
      d = (m_cyc / REFRESH_DIV - 1) % DIGITS;
      if (act != m_sel) begin
        m_sel = act; m_an = 4'hF; m_seg = 7'h7F;
      end else begin
        m_an  = 4'hF ^ (4'(1) << d);
        m_seg = bus.src_seg[(m_sel * DIGITS + d) * 7 +: 7];
      end
    end
    adv = m_pulse;
    if (!bus.mode) m_age = 0;
    else if (m_pulse != 0) m_age = 0;
    else begin
      m_age++;
      if (m_age == AUTO_PERIOD) begin adv = 1; m_age = 0; end
    end
    if (adv != 0) m_step = (m_step + 1) % NCH;
    pulse_now = 0;
    if (sync != m_acc) begin
      m_run++;
      if (m_run == DEB_CYCLES) begin m_acc = sync; m_run = 0; pulse_now = sync; end
    end else begin
      m_run = 0;
    end
    m_pulse = pulse_now;
    m_s2 = m_s1;
    m_s1 = int'(bus.btn_next);
  endtask

  // Model update on each edge, comparison on the opposite edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) m_reset(); else m_clock();
      @(negedge clk);
      if (chk_en) begin
        check("seg", int'(bus.seg), int'(m_seg));
        check("an",  int'(bus.an),  int'(m_an));
        check("sel", int'(bus.sel), m_sel);
      end
    end
  end

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic press(input int hi, input int lo);
    bus.btn_next = 1'b1;
    step_n(hi);
    bus.btn_next = 1'b0;
    step_n(lo);
  endtask

  logic [3:0] an_tab  [4];
  logic [6:0] seg_tab [4];
  int         wrap_tab[4];
  int         seg_left;

  initial begin
    an_tab   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab  = '{7'h01, 7'h02, 7'h04, 7'h08};
    wrap_tab = '{1, 2, 3, 0};
    bus.btn_next = 1'b0;
    bus.mode     = 1'b0;
    bus.force_en = '0;
    for (int i = 0; i < int'(NCH * DIGITS); i++) bus.src_seg[i * 7 +: 7] = 7'($urandom);
    for (int i = 0; i < 4; i++) bus.src_seg[i * 7 +: 7] = seg_tab[i];

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #2;
    check("rst_seg", int'(bus.seg), 7'h7F);
    check("rst_an",  int'(bus.an),  4'hF);
    check("rst_sel", int'(bus.sel), 0);

    // Reset and scan
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #2;
      if (n == 3) begin
        check("pre_slot_an",  int'(bus.an),  4'hF);
        check("pre_slot_seg", int'(bus.seg), 7'h7F);
      end
      if (n % 4 == 0) begin
        check("scan_an",  int'(bus.an),  int'(an_tab[(n / 4 - 1) % 4]));
        check("scan_seg", int'(bus.seg), int'(seg_tab[(n / 4 - 1) % 4]));
        check("scan_sel", int'(bus.sel), 0);
      end
    end

    // Debounce: short bounces ignored, stable level gives one advance
    step_n(1);
    press(3, 3);
    press(3, 3);
    #1 check("bounce_sel", int'(bus.sel), 0);
    press(20, 30);
    #1 check("deb_sel", int'(bus.sel), 1);

    // Wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(12, 12);
      #1 check("wrap_sel", int'(bus.sel), wrap_tab[i]);
    end

    // Priority force
    step_n(1);
    bus.force_en = 4'b1010;
    step_n(10);
    #1 check("force_sel", int'(bus.sel), 1);
    bus.force_en = '0;
    step_n(10);
    #1 check("unforce_sel", int'(bus.sel), 0);

    // Auto mode with a press at cycle 25, then async reset mid-slot on channel 2
    bus.mode = 1'b1;
    do_reset();
    for (int n = 1; n <= 86; n++) begin
      step_n(1);
      if (n == 25) bus.btn_next = 1'b1;
      if (n == 45) bus.btn_next = 1'b0;
      #1;
      if (n == 44) check("auto_sel44", int'(bus.sel), 1);
      if (n == 79) check("auto_sel79", int'(bus.sel), 1);
      if (n == 80) check("auto_sel80", int'(bus.sel), 2);
      if (n == 86) check("auto_sel86", int'(bus.sel), 2);
    end
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_seg", int'(bus.seg), 7'h7F);
    check("async_an",  int'(bus.an),  4'hF);
    check("async_sel", int'(bus.sel), 0);

    // Randomised operation
    bus.mode = 1'b0;
    do_reset();
    seg_left = 0;
    for (int n = 0; n < 2500; n++) begin
      if (seg_left == 0) begin
        bus.btn_next = 1'($urandom_range(0, 1));
        seg_left = int'($urandom_range(1, 14));
      end else begin
        seg_left--;
      end
      if ($urandom_range(0, 7) == 0)
        bus.src_seg[$urandom_range(0, NCH * DIGITS - 1) * 7 +: 7] = 7'($urandom);
      if ($urandom_range(0, 59) == 0)
        bus.force_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 299) == 0) bus.mode = ~bus.mode;
      step_n(1);
    end

    step_n(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_source_mux.md
# seg_source_mux

Parametrised N-channel source arbiter and scan driver for the board's multiplexed seven-segment display. It selects one of NCH display sources by forced priority, by debounced push-button stepping, or by timed auto-rotation, then scans that source's per-digit patterns onto the shared seg/an pins. It sits at the top level between the function sub-blocks and the display pins, replacing a fixed two-way select.

## Interface
- NCH, 4: number of display sources, 2..8.
- DIGITS, 4: number of display digits, 1..8.
- REFRESH_DIV, 100000: clocks per digit scan slot, ≥2.
- DEB_CYCLES, 500000: clocks a synchronised button level must stay stable before it is accepted, ≥2.
- AUTO_PERIOD, 100000000: clocks between automatic channel advances, ≥2.
- CLOCK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw, bouncy push-button that advances the channel.
- mode  in  1  0 = manual stepping, 1 = auto-rotate.
- force_en  in  NCH  per-channel priority override; bit i forces channel i.
- src_seg  in  NCH*DIGITS*7  active-low patterns. Channel c, digit d occupies bits [(c*DIGITS+d)*7 +: 7]. Digit 0 is the rightmost digit.
- seg  out  7  active-low segments, registered.
- an  out  DIGITS  active-low digit enables, registered, at most one bit low.
- sel  out  clog2(NCH) (min 1)  currently displayed channel, registered.

## Operation
- **Debouncer**
  - btn_next passes through a 2-FF synchroniser.
  - A counter counts while the synchronised level differs from the accepted level; it clears when they match.
  - When the counter reaches DEB_CYCLES, the accepted level takes the synchronised level.
  - A 0→1 transition of the accepted level produces a one-cycle next_pulse.
- **Step register**
  - In manual mode: next_pulse increments the register.
  - In auto mode: an auto timer counts 0..AUTO_PERIOD-1. On the terminal count it emits a tick and the register increments.
  - In auto mode, next_pulse also increments the register and restarts the auto timer at 0. If next_pulse and the tick coincide, the register advances by one only.
  - Increment wraps from NCH-1 to 0.
  - While mode=0 the auto timer is held at 0.
- **Selection**
  - If force_en is nonzero, the active channel is the lowest set index.
  - Otherwise the active channel is the step register.
  - While forced, the step register still advances on pulses and ticks. Releasing force returns to the step register's current value.
- **Scanner**
  - A refresh counter counts 0..REFRESH_DIV-1.
  - On its terminal count, the digit index advances, wrapping DIGITS-1→0.
  - Registered outputs are updated on that slot boundary only.
- **Anti-ghost blank**
  - When the active channel differs from sel at a slot boundary, that slot is blank: an = all 1s, seg = 7'h7F, and sel is updated to the new channel.
  - The next slot drives the new channel.
  - A change that reverts before the boundary causes no blank.

## Timing
- **Reset (asynchronous)**: seg = 7'h7F, an = all 1s, sel = 0. The step register, digit index, all counters and the accepted button level are 0.
- **First slot after reset**: first update is at the end of the first refresh period, REFRESH_DIV cycles after reset deassertion, and shows digit 0 of channel 0.
- **Normal slot**: on the boundary edge, an has bit d low and seg = src_seg[channel sel, digit d]. Values are sampled on that edge and held for REFRESH_DIV cycles; src_seg changes mid-slot are not visible until the next slot.
- **Button latency**: press to next_pulse takes 2 (sync) + DEB_CYCLES cycles. Step register updates the following cycle; the display changes at the next slot boundary (blank slot first).
- **Glitches**: a bounce shorter than DEB_CYCLES produces no pulse. Holding the button produces exactly one pulse; release produces none.
- **Mid-operation reset**: reset asserted during any slot returns all outputs to their reset values immediately, with no dependence on the clock.

## Test plan
- **Reset and scan**
  - Params: NCH=4, DIGITS=4, REFRESH_DIV=4, DEB_CYCLES=8.
  - Release reset, channel 0 patterns 7'h01/02/04/08.
  - Required: an = 1110/1101/1011/0111 cycling every 4 clocks with seg 01/02/04/08; sel=0; reset values before the first boundary.
- **Debounce**
  - Apply btn bounce pulses of 3 clocks, then a stable high for 20 clocks.
  - Required: exactly one sel increment (0→1), one blank slot, then channel 1 patterns; no change on release.
- **Wrap**
  - Apply four clean presses from sel=0.
  - Required: sel sequence 1, 2, 3, 0.
- **Priority force**
  - Set force_en=4'b1010 with the step register at 0, then clear force_en.
  - Required: sel=1 after the blank slot; after clearing, sel returns to 0 with one more blank slot.
- **Auto mode**
  - mode=1, AUTO_PERIOD=40; press the button at cycle 25.
  - Required: advance at the press; next auto advance 40 cycles after the pulse, not at cycle 40.
- **Async reset mid-slot**
  - Assert reset 2 clocks into a slot showing channel 2.
  - Required: seg=7'h7F, an=1111, sel=0 within the same cycle, without a clock edge.
